// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Holds the program counter, issues one word read at a
// time to instruction memory over a req/ack handshake, buffers returned
// instructions together with their PCs in a small queue, and presents the queue
// head to decode over valid/ready. A redirect from the control path flushes the
// queue and restarts fetch at the (word-aligned) target; a request already in
// flight when the redirect arrives is allowed to complete and its data dropped.
//
// Ports
//   clk              clock, all state on the rising edge
//   rst_n            asynchronous active-low reset
//   imem_req         read request, held until acked
//   imem_addr        word address of the request, stable while imem_req is high
//   imem_ack         one-cycle pulse, imem_rdata valid in that cycle
//   imem_rdata       returned instruction
//   redirect_valid   taken branch/jump: discard the current path
//   redirect_target  new PC (bits [1:0] ignored)
//   instr_valid      queue head valid
//   instr_ready      decode accepts the head this cycle
//   instr            queue head instruction
//   instr_pc         PC of the queue head
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       DEPTH         = 2,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_ack,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // IDLE: nothing outstanding. REQ: outstanding, data kept.
  // DROP: outstanding, data belongs to a flushed path and is discarded.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;

  logic [ADDRESS_WIDTH-1:0]  pc_mem_q   [DEPTH];
  logic [DATA_WIDTH-1:0]     data_mem_q [DEPTH];

  logic                      queue_valid;
  logic                      push;
  logic                      pop;
  logic                      can_issue;
  logic [ADDRESS_WIDTH-1:0]  target_aligned;
  logic [ADDRESS_WIDTH-1:0]  pc_plus4;

  assign queue_valid    = (count_q != '0);
  assign target_aligned = redirect_target & ~(ADDRESS_WIDTH'(3));
  assign pc_plus4       = fetch_pc_q + ADDRESS_WIDTH'(4);

  // A redirect cancels any push or pop happening in the same cycle.
  assign push = (state_q == REQ) && imem_ack && !redirect_valid;
  assign pop  = queue_valid && instr_ready && !redirect_valid;

  // Queue occupancy and pointers.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect_valid) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Issue only if the queue will still have room once this cycle's push/pop
  // land, so every outstanding request is guaranteed a slot on return.
  assign can_issue = (count_d < CNT_W'(DEPTH));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Next-state and fetch PC.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      IDLE: begin
        // A late ack seen here belongs to nothing and is ignored.
        if (redirect_valid) begin
          fetch_pc_d = target_aligned;
          state_d    = REQ;
        end else if (can_issue) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          fetch_pc_d = target_aligned;
          // Memory cannot cancel a request: without the ack we must wait it out.
          state_d    = imem_ack ? REQ : DROP;
        end else if (imem_ack) begin
          fetch_pc_d = pc_plus4;
          state_d    = can_issue ? REQ : IDLE;
        end
      end
      DROP: begin
        if (redirect_valid) fetch_pc_d = target_aligned;
        if (imem_ack)       state_d    = REQ;
      end
      default: state_d = IDLE;
    endcase
    // While draining a stale request the address must not move; otherwise the
    // request address simply follows the fetch PC.
    addr_d = (state_d == DROP) ? addr_q : fetch_pc_d;
  end

  // Outputs, all from registered state.
  always_comb begin
    imem_req    = (state_q != IDLE);
    imem_addr   = addr_q;
    instr_valid = queue_valid;
    instr       = queue_valid ? data_mem_q[rd_ptr_q] : '0;
    instr_pc    = queue_valid ? pc_mem_q[rd_ptr_q]   : '0;
  end

  // Queue storage; contents are only observed through the valid-gated outputs,
  // so the entries themselves need no reset.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_q == PTR_W'(gi))) begin
          pc_mem_q[gi]   <= fetch_pc_q;
          data_mem_q[gi] <= imem_rdata;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  // memory model and stray-ack injector
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stray_ack;
  int          mem_cnt;
  int          mem_lat;
  bit          mem_rand;
  logic [31:0] mem_hold;

  // second instance for the wrap test, hand driven
  logic        req_w;
  logic [31:0] addr_w;
  logic        ack_w;
  logic [31:0] rdata_w;
  logic        valid_w;
  logic [31:0] instr_w;
  logic [31:0] pc_w;

  int n_checks = 0;
  int n_fail   = 0;

  assign imem_ack   = mem_ack | stray_ack;
  assign imem_rdata = stray_ack ? 32'hDEAD_BEEF : mem_rdata;

  fetch_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  fetch_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(2), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req_w), .imem_addr(addr_w), .imem_ack(ack_w), .imem_rdata(rdata_w),
    .redirect_valid(1'b0), .redirect_target(32'h0),
    .instr_valid(valid_w), .instr_ready(1'b0), .instr(instr_w), .instr_pc(pc_w)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] idata(input logic [31:0] a);
    return (a ^ 32'h5A5A_0F0F) + 32'h0000_1111;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory: acks after mem_lat+1 sampled cycles of a request, checks that the
  // address stays put while the request waits.
  initial begin
    mem_ack = 1'b0; mem_rdata = '0; mem_cnt = 0; mem_lat = 1; mem_rand = 0; mem_hold = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        mem_ack = 1'b0;
        mem_cnt = 0;
      end else begin
        if (mem_ack) begin
          mem_ack = 1'b0;
          mem_cnt = 0;
        end
        if (imem_req) begin
          if (mem_cnt == 0) mem_hold = imem_addr;
          else chk("addr_stable", imem_addr, mem_hold);
          mem_cnt++;
          if (mem_cnt > mem_lat) begin
            mem_ack   = 1'b1;
            mem_rdata = idata(imem_addr);
            if (mem_rand) mem_lat = $urandom_range(1, 3);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    stray_ack = 1'b0; ack_w = 1'b0; rdata_w = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] target;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] t,
                              input logic q, input logic [31:0] a, input logic v,
                              input logic [31:0] p);
    vec_t x;
    x.ready = r; x.redir = rv; x.target = t;
    x.e_req = q; x.e_addr = a; x.e_valid = v; x.e_pc = p;
    x.e_instr = v ? idata(p) : 32'h0;
    return x;
  endfunction

  vec_t vecs[17];
  logic        acked, found, v, rdy, rv;
  logic [31:0] p, d, tg, model_pc;
  logic        flush_chk;
  int          pops;

  initial begin
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    stray_ack = 1'b0; ack_w = 1'b0; rdata_w = '0;

    // Per-cycle table, memory latency 1: backpressure fill, drain, redirect in IDLE.
    vecs[0]  = mk(0, 0, 32'h0,   1, 32'h0,   0, 32'h0);
    vecs[1]  = mk(0, 0, 32'h0,   1, 32'h0,   0, 32'h0);
    vecs[2]  = mk(0, 0, 32'h0,   1, 32'h4,   1, 32'h0);
    vecs[3]  = mk(0, 0, 32'h0,   1, 32'h4,   1, 32'h0);
    vecs[4]  = mk(0, 0, 32'h0,   0, 32'h8,   1, 32'h0);
    vecs[5]  = mk(0, 0, 32'h0,   0, 32'h8,   1, 32'h0);
    vecs[6]  = mk(0, 0, 32'h0,   0, 32'h8,   1, 32'h0);
    vecs[7]  = mk(1, 0, 32'h0,   1, 32'h8,   1, 32'h4);
    vecs[8]  = mk(1, 0, 32'h0,   1, 32'h8,   0, 32'h0);
    vecs[9]  = mk(1, 0, 32'h0,   1, 32'hC,   1, 32'h8);
    vecs[10] = mk(0, 0, 32'h0,   1, 32'hC,   1, 32'h8);
    vecs[11] = mk(0, 0, 32'h0,   0, 32'h10,  1, 32'h8);
    vecs[12] = mk(1, 1, 32'h103, 1, 32'h100, 0, 32'h0);
    vecs[13] = mk(1, 0, 32'h0,   1, 32'h100, 0, 32'h0);
    vecs[14] = mk(1, 0, 32'h0,   1, 32'h104, 1, 32'h100);
    vecs[15] = mk(1, 0, 32'h0,   1, 32'h104, 0, 32'h0);
    vecs[16] = mk(1, 0, 32'h0,   1, 32'h108, 1, 32'h104);

    // ---- reset values ----
    mem_lat = 1; mem_rand = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req",   imem_req,    1'b0);
    chk("rst_addr",  imem_addr,   32'h0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr,       32'h0);
    chk("rst_pc",    instr_pc,    32'h0);
    chk("rst_addr_w", addr_w,     32'hFFFF_FFFC);

    // ---- table ----
    do_reset();
    for (int i = 0; i < 17; i++) begin
      instr_ready = vecs[i].ready;
      redirect_valid = vecs[i].redir;
      redirect_target = vecs[i].target;
      @(posedge clk); #2;
      chk($sformatf("tbl%0d_req", i),   imem_req,    vecs[i].e_req);
      chk($sformatf("tbl%0d_addr", i),  imem_addr,   vecs[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), instr_valid, vecs[i].e_valid);
      chk($sformatf("tbl%0d_pc", i),    instr_pc,    vecs[i].e_pc);
      chk($sformatf("tbl%0d_instr", i), instr,       vecs[i].e_instr);
      $display("table row %0d: req=%0b addr=0x%0h valid=%0b pc=0x%0h", i, imem_req, imem_addr, instr_valid, instr_pc);
    end
    redirect_valid = 1'b0;

    // ---- redirect while a request is outstanding (latency 3) ----
    mem_lat = 3;
    do_reset();
    instr_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #2;
      if (imem_req && imem_addr == 32'h8) found = 1;
    end
    chk("drop_reach8", found, 1'b1);
    redirect_valid = 1'b1; redirect_target = 32'h40;
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    chk("drop_req",   imem_req,    1'b1);
    chk("drop_addr",  imem_addr,   32'h8);
    chk("drop_valid", instr_valid, 1'b0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk); acked = imem_ack;
      @(posedge clk); #2;
      if (acked) begin
        found = 1;
        chk("drop_after_req",  imem_req,  1'b1);
        chk("drop_after_addr", imem_addr, 32'h40);
      end else begin
        chk("drop_hold_addr",  imem_addr,   32'h8);
        chk("drop_hold_valid", instr_valid, 1'b0);
      end
    end
    chk("drop_ack_seen", found, 1'b1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #2;
      if (instr_valid) begin
        found = 1;
        chk("drop_first_pc",    instr_pc, 32'h40);
        chk("drop_first_instr", instr,    idata(32'h40));
      end
    end
    chk("drop_first_seen", found, 1'b1);
    $display("redirect-while-outstanding sequence done");

    // ---- redirect + ack + pop in the same cycle ----
    mem_lat = 1;
    do_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (imem_ack && instr_valid) found = 1;
    end
    chk("simul_setup", found, 1'b1);
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h200;
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    chk("simul_valid", instr_valid, 1'b0);
    chk("simul_req",   imem_req,    1'b1);
    chk("simul_addr",  imem_addr,   32'h200);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #2;
      if (instr_valid) begin
        found = 1;
        chk("simul_first_pc", instr_pc, 32'h200);
      end
    end
    chk("simul_first_seen", found, 1'b1);
    $display("simultaneous redirect/ack/pop sequence done");

    // ---- push + pop with one entry ----
    do_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (imem_ack && instr_valid) found = 1;
    end
    chk("pp_setup", found, 1'b1);
    instr_ready = 1'b1;
    @(posedge clk); #2;
    chk("pp_valid", instr_valid, 1'b1);
    chk("pp_pc",    instr_pc,    32'h4);
    chk("pp_addr",  imem_addr,   32'h8);
    @(posedge clk); #2;
    chk("pp_count1_then_empty", instr_valid, 1'b0);
    $display("push+pop sequence done");

    // ---- PC wrap on the second instance ----
    do_reset();
    @(posedge clk); #2;
    chk("wrap_addr0", addr_w, 32'hFFFF_FFFC);
    chk("wrap_req0",  req_w,  1'b1);
    @(negedge clk);
    ack_w = 1'b1; rdata_w = idata(32'hFFFF_FFFC);
    @(posedge clk); #2;
    ack_w = 1'b0;
    chk("wrap_addr1", addr_w,  32'h0);
    chk("wrap_valid", valid_w, 1'b1);
    chk("wrap_pc",    pc_w,    32'hFFFF_FFFC);
    chk("wrap_instr", instr_w, idata(32'hFFFF_FFFC));
    $display("wrap sequence done: second fetch addr=0x%0h", addr_w);

    // ---- async reset mid-request, then a stray ack in IDLE ----
    do_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #2;
      if (instr_valid && imem_req) found = 1;
    end
    chk("arst_setup", found, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_req",   imem_req,    1'b0);
    chk("arst_valid", instr_valid, 1'b0);
    chk("arst_addr",  imem_addr,   32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; stray_ack = 1'b1;
    @(posedge clk); #2;
    stray_ack = 1'b0;
    chk("stray_valid1", instr_valid, 1'b0);
    chk("stray_req",    imem_req,    1'b1);
    chk("stray_addr",   imem_addr,   32'h0);
    @(posedge clk); #2;
    chk("stray_valid2", instr_valid, 1'b0);
    @(posedge clk); #2;
    chk("stray_valid3", instr_valid, 1'b1);
    chk("stray_pc",     instr_pc,    32'h0);
    chk("stray_instr",  instr,       idata(32'h0));
    $display("async reset / stray ack sequence done");

    // ---- random traffic against the sequential-stream model ----
    mem_lat = 1; mem_rand = 1;
    do_reset();
    model_pc = 32'h0; flush_chk = 0; pops = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      v = instr_valid; p = instr_pc; d = instr;
      if (flush_chk) chk("rand_flush_valid", v, 1'b0);
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      tg  = $urandom;
      instr_ready = rdy; redirect_valid = rv; redirect_target = tg;
      flush_chk = rv;
      if (rv) begin
        model_pc = tg & ~32'h3;
      end else if (v && rdy) begin
        chk("rand_pc",    p, model_pc);
        chk("rand_instr", d, idata(model_pc));
        model_pc = model_pc + 32'h4;
        pops++;
      end
    end
    @(negedge clk);
    instr_ready = 1'b0; redirect_valid = 1'b0; mem_rand = 0;
    chk("rand_progress", (pops > 100), 1'b1);
    $display("random phase: %0d instructions consumed", pops);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
